// File: rtl/fifo_shift_round_if.sv
// Handshake bundle for fifo_shift_round: input word channel plus output word channel.
// The slave modport is the converter; the master modport is whoever drives and drains it.
interface fifo_shift_round_if #(
    parameter int unsigned IWidth = 8,
    parameter int unsigned OWidth = 8
);
    logic [IWidth-1:0] InData;
    logic              InValid;
    logic              InAccept;
    logic [OWidth-1:0] OutData;
    logic              OutValid;
    logic              OutReady;

    modport slave (
        input  InData,
        input  InValid,
        input  OutReady,
        output InAccept,
        output OutData,
        output OutValid
    );

    modport master (
        output InData,
        output InValid,
        output OutReady,
        input  InAccept,
        input  OutData,
        input  OutValid
    );
endinterface

// File: rtl/fifo_shift_round.sv
// Handshaked width converter: splits a wide word into narrow chunks, packs narrow words
// into a wide one, or acts as a one-entry register stage when the widths match.
module fifo_shift_round #(
    parameter int unsigned IWidth  = 8,
    parameter int unsigned OWidth  = 8,
    parameter int unsigned Reverse = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    fifo_shift_round_if.slave bus
);

    if (IWidth > OWidth) begin : g_down
        localparam int unsigned NW    = OWidth;
        localparam int unsigned RATIO = (IWidth + NW - 1) / NW;
        localparam int unsigned CW    = RATIO * NW;
        localparam int unsigned CNT_W = $clog2(RATIO + 1);

        logic [CW-1:0]    data_q, data_d;
        logic [CNT_W-1:0] k_q, k_d;
        logic             full_q, full_d;
        logic             last_c, out_xfer_c, in_accept_c, in_xfer_c;

        assign last_c      = (k_q == CNT_W'(RATIO - 1));
        assign out_xfer_c  = full_q & bus.OutReady;
        assign in_accept_c = ~Reset & (~full_q | (out_xfer_c & last_c));
        assign in_xfer_c   = bus.InValid & in_accept_c;

        // The emitted chunk always sits at one end of the register; each transfer shifts the next one in.
        always_comb begin
            data_d = data_q;
            k_d    = k_q;
            full_d = full_q;
            if (out_xfer_c) begin
                data_d = (Reverse != 0) ? (data_q << NW) : (data_q >> NW);
                k_d    = k_q + CNT_W'(1);
                if (last_c) begin
                    full_d = 1'b0;
                    k_d    = '0;
                end
            end
            if (in_xfer_c) begin
                data_d = CW'(bus.InData);
                k_d    = '0;
                full_d = 1'b1;
            end
        end

        always_ff @(posedge Clock) begin
            if (Reset) begin
                data_q <= '0;
                k_q    <= '0;
                full_q <= 1'b0;
            end else begin
                data_q <= data_d;
                k_q    <= k_d;
                full_q <= full_d;
            end
        end

        assign bus.InAccept = in_accept_c;
        assign bus.OutValid = full_q;
        assign bus.OutData  = (Reverse != 0) ? data_q[CW-1 -: NW] : data_q[NW-1:0];

    end else if (IWidth < OWidth) begin : g_up
        localparam int unsigned NW    = IWidth;
        localparam int unsigned RATIO = (OWidth + NW - 1) / NW;
        localparam int unsigned CW    = RATIO * NW;
        localparam int unsigned CNT_W = $clog2(RATIO + 1);

        logic [CW-1:0]    coll_q, coll_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             valid_q, valid_d;
        logic             out_xfer_c, in_accept_c, in_xfer_c;

        assign out_xfer_c  = valid_q & bus.OutReady;
        assign in_accept_c = ~Reset & (~valid_q | bus.OutReady);
        assign in_xfer_c   = bus.InValid & in_accept_c;

        // Words shift in from one end so that after RATIO inserts the first lands in its final chunk.
        always_comb begin
            coll_d = coll_q;
            cnt_d  = cnt_q;
            if (out_xfer_c) begin
                coll_d = '0;
                cnt_d  = '0;
            end
            if (in_xfer_c) begin
                if (Reverse != 0) begin
                    coll_d = {coll_d[CW-NW-1:0], bus.InData};
                end else begin
                    coll_d = {bus.InData, coll_d[CW-1:NW]};
                end
                cnt_d = cnt_d + CNT_W'(1);
            end
            valid_d = (cnt_d == CNT_W'(RATIO));
        end

        always_ff @(posedge Clock) begin
            if (Reset) begin
                coll_q  <= '0;
                cnt_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                coll_q  <= coll_d;
                cnt_q   <= cnt_d;
                valid_q <= valid_d;
            end
        end

        assign bus.InAccept = in_accept_c;
        assign bus.OutValid = valid_q;
        assign bus.OutData  = coll_q[OWidth-1:0];

    end else begin : g_equal
        logic [IWidth-1:0] data_q, data_d;
        logic              valid_q, valid_d;
        logic              in_accept_c, in_xfer_c;

        assign in_accept_c = ~Reset & (~valid_q | bus.OutReady);
        assign in_xfer_c   = bus.InValid & in_accept_c;

        always_comb begin
            data_d  = data_q;
            valid_d = valid_q;
            if (valid_q & bus.OutReady) begin
                valid_d = 1'b0;
            end
            if (in_xfer_c) begin
                data_d  = bus.InData;
                valid_d = 1'b1;
            end
        end

        always_ff @(posedge Clock) begin
            if (Reset) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign bus.InAccept = in_accept_c;
        assign bus.OutValid = valid_q;
        assign bus.OutData  = data_q;
    end

endmodule

// File: tb/tb_fifo_shift_round.sv
// Bench for fifo_shift_round: eight configurations share one stimulus/observation path
// selected by sel, and are checked against queue-based chunk models.
module tb_fifo_shift_round;

    localparam int S_D104 = 0;
    localparam int S_U32R0 = 1;
    localparam int S_U32R1 = 2;
    localparam int S_D32 = 3;
    localparam int S_D12R0 = 4;
    localparam int S_D12R1 = 5;
    localparam int S_U12 = 6;
    localparam int S_EQ = 7;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic [127:0] drv_data = '0;
    logic         drv_valid = 1'b0;
    logic         drv_ready = 1'b0;
    int           sel = 0;
    logic         obs_accept, obs_valid;
    logic [127:0] obs_data;
    int           pass_cnt = 0;
    int           total_cnt = 0;
    logic [127:0] words_q[$];
    logic [127:0] got_q[$];

    always #5 Clock = ~Clock;

    fifo_shift_round_if #(.IWidth(104), .OWidth(8))  if_d104 ();
    fifo_shift_round_if #(.IWidth(8),   .OWidth(32)) if_u32r0 ();
    fifo_shift_round_if #(.IWidth(8),   .OWidth(32)) if_u32r1 ();
    fifo_shift_round_if #(.IWidth(32),  .OWidth(8))  if_d32 ();
    fifo_shift_round_if #(.IWidth(12),  .OWidth(8))  if_d12r0 ();
    fifo_shift_round_if #(.IWidth(12),  .OWidth(8))  if_d12r1 ();
    fifo_shift_round_if #(.IWidth(8),   .OWidth(12)) if_u12 ();
    fifo_shift_round_if #(.IWidth(8),   .OWidth(8))  if_eq ();

    fifo_shift_round #(.IWidth(104), .OWidth(8),  .Reverse(1)) u_d104   (.Clock(Clock), .Reset(Reset), .bus(if_d104.slave));
    fifo_shift_round #(.IWidth(8),   .OWidth(32), .Reverse(0)) u_u32r0  (.Clock(Clock), .Reset(Reset), .bus(if_u32r0.slave));
    fifo_shift_round #(.IWidth(8),   .OWidth(32), .Reverse(1)) u_u32r1  (.Clock(Clock), .Reset(Reset), .bus(if_u32r1.slave));
    fifo_shift_round #(.IWidth(32),  .OWidth(8),  .Reverse(0)) u_d32    (.Clock(Clock), .Reset(Reset), .bus(if_d32.slave));
    fifo_shift_round #(.IWidth(12),  .OWidth(8),  .Reverse(0)) u_d12r0  (.Clock(Clock), .Reset(Reset), .bus(if_d12r0.slave));
    fifo_shift_round #(.IWidth(12),  .OWidth(8),  .Reverse(1)) u_d12r1  (.Clock(Clock), .Reset(Reset), .bus(if_d12r1.slave));
    fifo_shift_round #(.IWidth(8),   .OWidth(12), .Reverse(0)) u_u12    (.Clock(Clock), .Reset(Reset), .bus(if_u12.slave));
    fifo_shift_round #(.IWidth(8),   .OWidth(8),  .Reverse(1)) u_eq     (.Clock(Clock), .Reset(Reset), .bus(if_eq.slave));

    // Only the selected instance sees valid/ready; the others sit idle.
    assign if_d104.InData   = drv_data[103:0];
    assign if_d104.InValid  = drv_valid && (sel == S_D104);
    assign if_d104.OutReady = drv_ready && (sel == S_D104);
    assign if_u32r0.InData   = drv_data[7:0];
    assign if_u32r0.InValid  = drv_valid && (sel == S_U32R0);
    assign if_u32r0.OutReady = drv_ready && (sel == S_U32R0);
    assign if_u32r1.InData   = drv_data[7:0];
    assign if_u32r1.InValid  = drv_valid && (sel == S_U32R1);
    assign if_u32r1.OutReady = drv_ready && (sel == S_U32R1);
    assign if_d32.InData   = drv_data[31:0];
    assign if_d32.InValid  = drv_valid && (sel == S_D32);
    assign if_d32.OutReady = drv_ready && (sel == S_D32);
    assign if_d12r0.InData   = drv_data[11:0];
    assign if_d12r0.InValid  = drv_valid && (sel == S_D12R0);
    assign if_d12r0.OutReady = drv_ready && (sel == S_D12R0);
    assign if_d12r1.InData   = drv_data[11:0];
    assign if_d12r1.InValid  = drv_valid && (sel == S_D12R1);
    assign if_d12r1.OutReady = drv_ready && (sel == S_D12R1);
    assign if_u12.InData   = drv_data[7:0];
    assign if_u12.InValid  = drv_valid && (sel == S_U12);
    assign if_u12.OutReady = drv_ready && (sel == S_U12);
    assign if_eq.InData   = drv_data[7:0];
    assign if_eq.InValid  = drv_valid && (sel == S_EQ);
    assign if_eq.OutReady = drv_ready && (sel == S_EQ);

    always_comb begin
        obs_accept = 1'b0;
        obs_valid  = 1'b0;
        obs_data   = '0;
        case (sel)
            S_D104:  begin obs_accept = if_d104.InAccept;  obs_valid = if_d104.OutValid;  obs_data = 128'(if_d104.OutData);  end
            S_U32R0: begin obs_accept = if_u32r0.InAccept; obs_valid = if_u32r0.OutValid; obs_data = 128'(if_u32r0.OutData); end
            S_U32R1: begin obs_accept = if_u32r1.InAccept; obs_valid = if_u32r1.OutValid; obs_data = 128'(if_u32r1.OutData); end
            S_D32:   begin obs_accept = if_d32.InAccept;   obs_valid = if_d32.OutValid;   obs_data = 128'(if_d32.OutData);   end
            S_D12R0: begin obs_accept = if_d12r0.InAccept; obs_valid = if_d12r0.OutValid; obs_data = 128'(if_d12r0.OutData); end
            S_D12R1: begin obs_accept = if_d12r1.InAccept; obs_valid = if_d12r1.OutValid; obs_data = 128'(if_d12r1.OutData); end
            S_U12:   begin obs_accept = if_u12.InAccept;   obs_valid = if_u12.OutValid;   obs_data = 128'(if_u12.OutData);   end
            default: begin obs_accept = if_eq.InAccept;    obs_valid = if_eq.OutValid;    obs_data = 128'(if_eq.OutData);    end
        endcase
    end

    function automatic logic [127:0] low_mask(input int n);
        return (n >= 128) ? '1 : ((128'd1 << n) - 128'd1);
    endfunction

    function automatic logic [127:0] chunk_of(input logic [127:0] w, input int n, input int i);
        return (w >> (i * n)) & low_mask(n);
    endfunction

    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'(cyc % 2);
        return 1'($urandom_range(0, 1));
    endfunction

    // Down model: each accepted word becomes a queue of chunks in emission order.
    task automatic run_down(input int s, input int iw, input int ow, input bit rev,
                            input int mode, output int cycles);
        int r;
        logic [127:0] expq[$];
        logic [127:0] w, prev_data;
        bit prev_stall, exp_acc;
        r = (iw + ow - 1) / ow;
        sel = s; cycles = 0; prev_stall = 0; prev_data = '0;
        got_q.delete();
        while ((words_q.size() > 0 || expq.size() > 0) && cycles < 2000) begin
            drv_valid = (words_q.size() > 0) && (mode != 2 || $urandom_range(0, 3) != 0);
            drv_data  = drv_valid ? words_q[0] : {$urandom(), $urandom(), $urandom(), $urandom()};
            drv_ready = pick_ready(mode, cycles);
            @(negedge Clock);
            exp_acc = (expq.size() == 0) || (expq.size() == 1 && drv_ready);
            total_cnt++;
            if (obs_valid !== (expq.size() > 0) || obs_accept !== exp_acc)
                $display("FAIL down_handshake sel=%0d cyc=%0d: valid=%b accept=%b, want valid=%b accept=%b",
                         s, cycles, obs_valid, obs_accept, expq.size() > 0, exp_acc);
            else pass_cnt++;
            if (prev_stall) begin
                total_cnt++;
                if (obs_data !== prev_data)
                    $display("FAIL down_hold sel=%0d cyc=%0d: data=%h, want held %h", s, cycles, obs_data, prev_data);
                else pass_cnt++;
            end
            if (obs_valid && drv_ready) begin
                total_cnt++;
                if (expq.size() == 0 || obs_data !== expq[0])
                    $display("FAIL down_data sel=%0d cyc=%0d: data=%h, want %h", s, cycles, obs_data,
                             (expq.size() > 0) ? expq[0] : 128'hx);
                else pass_cnt++;
                got_q.push_back(obs_data);
                if (expq.size() > 0) void'(expq.pop_front());
            end
            prev_stall = obs_valid && !drv_ready;
            prev_data  = obs_data;
            if (drv_valid && obs_accept) begin
                w = words_q.pop_front() & low_mask(iw);
                for (int k = 0; k < r; k++) expq.push_back(chunk_of(w, ow, rev ? (r - 1 - k) : k));
            end
            @(posedge Clock); #1;
            cycles++;
        end
        total_cnt++;
        if (words_q.size() != 0 || expq.size() != 0)
            $display("FAIL down_timeout sel=%0d: %0d words and %0d chunks left, want 0/0", s, words_q.size(), expq.size());
        else pass_cnt++;
        drv_valid = 1'b0; drv_ready = 1'b0;
    endtask

    // Up model: gather R accepted words, place word j at chunk j (or R-1-j), truncate to OWidth.
    task automatic run_up(input int s, input int iw, input int ow, input bit rev,
                          input int mode, output int cycles);
        int r;
        logic [127:0] cur[$];
        logic [127:0] outq[$];
        logic [127:0] w, prev_data;
        bit prev_stall, exp_acc;
        r = (ow + iw - 1) / iw;
        sel = s; cycles = 0; prev_stall = 0; prev_data = '0;
        got_q.delete();
        while ((words_q.size() > 0 || cur.size() > 0 || outq.size() > 0) && cycles < 3000) begin
            drv_valid = (words_q.size() > 0) && (mode != 2 || $urandom_range(0, 3) != 0);
            drv_data  = drv_valid ? words_q[0] : {$urandom(), $urandom(), $urandom(), $urandom()};
            drv_ready = pick_ready(mode, cycles);
            @(negedge Clock);
            exp_acc = (outq.size() == 0) || drv_ready;
            total_cnt++;
            if (obs_valid !== (outq.size() > 0) || obs_accept !== exp_acc)
                $display("FAIL up_handshake sel=%0d cyc=%0d: valid=%b accept=%b, want valid=%b accept=%b",
                         s, cycles, obs_valid, obs_accept, outq.size() > 0, exp_acc);
            else pass_cnt++;
            if (prev_stall) begin
                total_cnt++;
                if (obs_data !== prev_data)
                    $display("FAIL up_hold sel=%0d cyc=%0d: data=%h, want held %h", s, cycles, obs_data, prev_data);
                else pass_cnt++;
            end
            if (obs_valid && drv_ready) begin
                total_cnt++;
                if (outq.size() == 0 || obs_data !== outq[0])
                    $display("FAIL up_data sel=%0d cyc=%0d: data=%h, want %h", s, cycles, obs_data,
                             (outq.size() > 0) ? outq[0] : 128'hx);
                else pass_cnt++;
                got_q.push_back(obs_data);
                if (outq.size() > 0) void'(outq.pop_front());
            end
            prev_stall = obs_valid && !drv_ready;
            prev_data  = obs_data;
            if (drv_valid && obs_accept) begin
                cur.push_back(words_q.pop_front() & low_mask(iw));
                if (cur.size() == r) begin
                    w = '0;
                    for (int j = 0; j < r; j++) w = w | (cur[j] << ((rev ? (r - 1 - j) : j) * iw));
                    outq.push_back(w & low_mask(ow));
                    cur.delete();
                end
            end
            @(posedge Clock); #1;
            cycles++;
        end
        total_cnt++;
        if (words_q.size() != 0 || cur.size() != 0 || outq.size() != 0)
            $display("FAIL up_timeout sel=%0d: %0d/%0d/%0d items left, want 0/0/0", s, words_q.size(), cur.size(), outq.size());
        else pass_cnt++;
        drv_valid = 1'b0; drv_ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; drv_valid = 1'b1; drv_ready = 1'b1; drv_data = {4{32'hA5C3_5A3C}};
        repeat (3) @(posedge Clock);
        for (int s = 0; s < 8; s++) begin
            sel = s;
            @(negedge Clock);
            total_cnt++;
            if (obs_valid !== 1'b0 || obs_data !== '0 || obs_accept !== 1'b0)
                $display("FAIL reset_state sel=%0d: valid=%b data=%h accept=%b, want 0/0/0", s, obs_valid, obs_data, obs_accept);
            else pass_cnt++;
        end
        @(posedge Clock); #1;
        Reset = 1'b0; drv_valid = 1'b0; drv_ready = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel = s;
            @(negedge Clock);
            total_cnt++;
            if (obs_accept !== 1'b1 || obs_valid !== 1'b0)
                $display("FAIL reset_release sel=%0d: accept=%b valid=%b, want 1/0", s, obs_accept, obs_valid);
            else pass_cnt++;
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_down_msb_first();
        int cyc;
        logic [7:0] exp_b [13];
        exp_b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h04};
        words_q.delete();
        words_q.push_back(128'h01_00000002_00000003_00000004);
        run_down(S_D104, 104, 8, 1'b1, 0, cyc);
        total_cnt++;
        if (got_q.size() != 13 || cyc != 14)
            $display("FAIL down104_count: bytes=%0d cycles=%0d, want 13/14", got_q.size(), cyc);
        else pass_cnt++;
        for (int i = 0; i < got_q.size() && i < 13; i++) begin
            total_cnt++;
            if (got_q[i] !== 128'(exp_b[i]))
                $display("FAIL down104_byte%0d: got %h, want %h", i, got_q[i], exp_b[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_up_order();
        int cyc;
        logic [31:0] exp_w [2];
        exp_w = '{32'h44332211, 32'h11223344};
        for (int rv = 0; rv < 2; rv++) begin
            words_q.delete();
            words_q.push_back(128'h11); words_q.push_back(128'h22);
            words_q.push_back(128'h33); words_q.push_back(128'h44);
            run_up((rv == 0) ? S_U32R0 : S_U32R1, 8, 32, 1'(rv), 0, cyc);
            total_cnt++;
            if (got_q.size() != 1 || got_q[0] !== 128'(exp_w[rv]) || cyc != 5)
                $display("FAIL up32_rev%0d: words=%0d first=%h cycles=%0d, want 1/%h/5", rv, got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : 128'hx, cyc, exp_w[rv]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        words_q.delete();
        words_q.push_back(128'($urandom())); words_q.push_back(128'($urandom()));
        run_down(S_D32, 32, 8, 1'b0, 1, cyc);
        total_cnt++;
        if (got_q.size() != 8)
            $display("FAIL backpressure_count: bytes=%0d, want 8", got_q.size());
        else pass_cnt++;
    endtask

    task automatic test_padding();
        int cyc;
        logic [127:0] e0 [2];
        logic [127:0] e1 [2];
        e0 = '{128'hBC, 128'h0A};
        e1 = '{128'h0A, 128'hBC};
        words_q.delete(); words_q.push_back(128'hABC);
        run_down(S_D12R0, 12, 8, 1'b0, 0, cyc);
        total_cnt++;
        if (got_q.size() != 2 || got_q[0] !== e0[0] || got_q[1] !== e0[1])
            $display("FAIL pad_down_lsb: n=%0d %h %h, want BC 0A", got_q.size(), got_q[0], got_q[1]);
        else pass_cnt++;
        words_q.push_back(128'hABC);
        run_down(S_D12R1, 12, 8, 1'b1, 0, cyc);
        total_cnt++;
        if (got_q.size() != 2 || got_q[0] !== e1[0] || got_q[1] !== e1[1])
            $display("FAIL pad_down_msb: n=%0d %h %h, want 0A BC", got_q.size(), got_q[0], got_q[1]);
        else pass_cnt++;
        words_q.push_back(128'hBC); words_q.push_back(128'h0A);
        run_up(S_U12, 8, 12, 1'b0, 0, cyc);
        total_cnt++;
        if (got_q.size() != 1 || got_q[0] !== 128'hABC)
            $display("FAIL pad_up: n=%0d %h, want ABC", got_q.size(), (got_q.size() > 0) ? got_q[0] : 128'hx);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n, cyc;
        bit took;
        logic [7:0] exp_b [5];
        exp_b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        sel = S_D104; drv_data = 128'h01_00000002_00000003_00000004;
        drv_valid = 1'b1; drv_ready = 1'b1; n = 0; cyc = 0;
        while (n < 5 && cyc < 50) begin
            @(negedge Clock);
            if (obs_valid && drv_ready) begin
                total_cnt++;
                if (obs_data !== 128'(exp_b[n]))
                    $display("FAIL midreset_byte%0d: got %h, want %h", n, obs_data, exp_b[n]);
                else pass_cnt++;
                n++;
            end
            took = obs_accept && drv_valid;
            @(posedge Clock); #1;
            cyc++;
            if (took) drv_valid = 1'b0;
        end
        total_cnt++;
        if (n != 5) $display("FAIL midreset_timeout: %0d bytes seen, want 5", n);
        else pass_cnt++;
        Reset = 1'b1; drv_valid = 1'b1;
        @(negedge Clock);
        total_cnt++;
        if (obs_accept !== 1'b0) $display("FAIL midreset_accept: accept=%b during reset, want 0", obs_accept);
        else pass_cnt++;
        @(posedge Clock); #1;
        Reset = 1'b0; drv_valid = 1'b0;
        @(negedge Clock);
        total_cnt++;
        if (obs_valid !== 1'b0 || obs_data !== '0 || obs_accept !== 1'b1)
            $display("FAIL midreset_after: valid=%b data=%h accept=%b, want 0/0/1", obs_valid, obs_data, obs_accept);
        else pass_cnt++;
        @(posedge Clock); #1;
        words_q.delete();
        words_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        run_down(S_D104, 104, 8, 1'b1, 0, cyc);
    endtask

    task automatic test_equal();
        int cyc;
        words_q.delete();
        for (int i = 0; i < 256; i++) words_q.push_back(128'(i));
        run_up(S_EQ, 8, 8, 1'b0, 0, cyc);
        total_cnt++;
        if (cyc != 257 || got_q.size() != 256)
            $display("FAIL equal_throughput: cycles=%0d words=%0d, want 257/256", cyc, got_q.size());
        else pass_cnt++;
        for (int i = 0; i < 256; i++) words_q.push_back(128'(i));
        run_up(S_EQ, 8, 8, 1'b0, 2, cyc);
        total_cnt++;
        if (got_q.size() != 256) $display("FAIL equal_random_count: words=%0d, want 256", got_q.size());
        else pass_cnt++;
        for (int i = 0; i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] !== 128'(i)) $display("FAIL equal_seq%0d: got %h, want %h", i, got_q[i], i);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int cyc;
        int cfg_s [8];
        int cfg_iw [8];
        int cfg_ow [8];
        bit cfg_rev [8];
        cfg_s   = '{S_D104, S_U32R0, S_U32R1, S_D32, S_D12R0, S_D12R1, S_U12, S_EQ};
        cfg_iw  = '{104, 8, 8, 32, 12, 12, 8, 8};
        cfg_ow  = '{8, 32, 32, 8, 8, 8, 12, 8};
        cfg_rev = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 8; c++) begin
            words_q.delete();
            for (int i = 0; i < 12; i++) words_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
            if (cfg_iw[c] > cfg_ow[c]) run_down(cfg_s[c], cfg_iw[c], cfg_ow[c], cfg_rev[c], 2, cyc);
            else run_up(cfg_s[c], cfg_iw[c], cfg_ow[c], cfg_rev[c], 2, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_down_msb_first();
        test_up_order();
        test_backpressure();
        test_padding();
        test_reset_mid();
        test_equal();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_shift_round.md
Name: fifo_shift_round

Overview:
- Handshaked width converter, usable as a single-entry FIFO stage.
- Either serializes one wide input word into several narrow output words, or packs several narrow input words into one wide output word.
- Used on the UART paths: command words split into UART bytes; UART bytes packed into data words.
- The Reverse parameter selects chunk ordering (MSB-first vs LSB-first).

Parameters:
- IWidth, 8: input data width in bits, ≥1.
- OWidth, 8: output data width in bits, ≥1.
- Reverse, 0: 0 = chunk order starts at the LSB end; 1 = chunk order starts at the MSB end.

Ports:
- Clock  in  1  sole clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- InData  in  IWidth  input word.
- InValid  in  1  InData is valid.
- InAccept  out  1  block takes InData this cycle when InValid is also high.
- OutData  out  OWidth  output word.
- OutValid  out  1  OutData is valid.
- OutReady  in  1  consumer takes OutData this cycle when OutValid is also high.

Behaviour:
- Handshakes:
  - An input transfer occurs on a rising edge where InValid & InAccept.
  - An output transfer occurs on a rising edge where OutValid & OutReady.
  - OutData and OutValid are register outputs and stay stable while OutValid=1 and OutReady=0.
- Chunk ratio:
  - W = max(IWidth, OWidth), N = min(IWidth, OWidth), R = ceil(W/N).
  - The wide word is treated as R chunks of N bits, zero-padded at the MSB end to R*N bits.
  - Chunk 0 is bits [N-1:0].
- Reset (synchronous, while Reset=1):
  - Chunk counter = 0; OutValid = 0; data register = 0, so OutData = 0.
  - InAccept = 0 while Reset is high; InAccept = 1 in the first cycle after Reset drops.
- Down mode (IWidth > OWidth):
  - State: wide register plus chunk index k in 0..R-1, and a full flag.
  - InAccept = !full | (OutValid & OutReady & k==R-1), i.e. back-to-back words with no bubble.
  - On an input transfer: the register loads the zero-padded word, k=0, and OutValid=1 on the next cycle.
  - Emission order: Reverse=0 emits chunk k; Reverse=1 emits chunk R-1-k.
  - On each output transfer, k increments. After k=R-1 the stage empties unless a new word is loaded in the same cycle.
  - Padding bits are emitted as zeros, so the last LSB-first chunk (or first MSB-first chunk) carries the pad.
- Up mode (IWidth < OWidth):
  - State: collection register plus count c in 0..R. OutValid = (c==R).
  - InAccept = (c<R) | OutReady.
  - The j-th accepted word (j = 0..R-1) is written into chunk j when Reverse=0, or chunk R-1-j when Reverse=1.
  - OutData = the low OWidth bits of the R*N collection; padding is dropped.
  - OutValid rises the cycle after the R-th input transfer.
  - Simultaneous output and input transfer: the new word becomes chunk position 0 of the next word, c=1.
  - Unwritten chunk positions are zero at the start of each word.
- Equal widths (IWidth == OWidth):
  - One-entry register stage with InAccept = !OutValid | OutReady and latency 1 cycle.
  - Reverse is ignored.
- Reset asserted mid-word discards all partial state, with no output of partial words.
- InData is ignored when InAccept=0, and OutReady is ignored when OutValid=0.

Test Plan:
- Down, IWidth=104, OWidth=8, Reverse=1, OutReady=1; input 0x01_00000002_00000003_00000004 → 13 bytes in order 01,00,00,00,02,00,00,00,03,00,00,00,04. InAccept is high again on the cycle the last byte transfers.
- Up, IWidth=8, OWidth=32:
  - Bytes 11,22,33,44 with Reverse=0 → 0x44332211.
  - Same bytes with Reverse=1 → 0x11223344.
  - OutValid rises exactly one cycle after the 4th accept.
- Backpressure, down 32→8 with OutReady toggling 0/1 each cycle: OutData is held stable while not accepted, and InAccept stays 0 until the last chunk transfers. Two back-to-back input words yield 8 bytes, none lost or duplicated.
- Padding, IWidth=12, OWidth=8, input 0xABC:
  - Reverse=0 → 0xBC, 0x0A.
  - Reverse=1 → 0x0A, 0xBC.
  - Up 8→12, Reverse=0, with bytes BC,0A → 0xABC.
- Reset mid-operation, down 104→8: assert Reset after 5 bytes have transferred. The next cycle has OutValid=0 and OutData=0. A new word then starts from its first chunk.
- Equal widths, 8→8: stream 0..255 with random OutReady → identical sequence out, 1-cycle latency, full throughput when OutReady=1.
